// File: rtl/duty_slew.sv
// Slew-limited duty command generator.
// Steps duty toward a latched target once per PWM frame.
module duty_slew #(
  parameter int PERIOD = 8192
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tgt_wrt,
  input  logic [13:0] tgt,
  input  logic [7:0]  step,
  input  logic        estop,
  output logic [13:0] duty,
  output logic        wrt_duty,
  output logic        settled
);

  localparam int FW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RAMP = 1'b1;

  logic [0:0]    state, state_n;
  logic [FW-1:0] fcnt, fcnt_n;
  logic [13:0]   tgt_q, tgt_n;
  logic [7:0]    step_q, step_n;
  logic [13:0]   cur, cur_n;
  logic [13:0]   tgt_in, nxt;
  logic [14:0]   diff, mag;
  logic          tick, upd, wrt_n, settled_n;

  assign tick = (fcnt == FW'(PERIOD - 1));
  // -8192 has no positive mirror, so keep targets symmetric
  assign tgt_in = (tgt == 14'h2000) ? 14'h2001 : tgt;
  assign upd = (state == RAMP) && tick && (cur != tgt_q);

  always_comb begin
    diff = {tgt_q[13], tgt_q} - {cur[13], cur};
    mag = diff[14] ? (15'd0 - diff) : diff;
    nxt = tgt_q;
    if (step_q != 8'd0 && mag > {7'd0, step_q}) begin
      if (!diff[14]) nxt = cur + {6'd0, step_q};
      else           nxt = cur - {6'd0, step_q};
    end
  end

  always_comb begin
    cur_n   = cur;
    tgt_n   = tgt_q;
    step_n  = step_q;
    state_n = state;
    fcnt_n  = tick ? '0 : fcnt + 1'b1;
    wrt_n   = 1'b0;
    if (estop) begin
      cur_n   = '0;
      tgt_n   = '0;
      fcnt_n  = '0;
      state_n = IDLE;
      wrt_n   = (cur != 14'd0);
    end else begin
      if (tgt_wrt) begin
        tgt_n  = tgt_in;
        step_n = step;
      end
      if (upd) begin
        cur_n = nxt;
        wrt_n = 1'b1;
      end
      unique case (state)
        IDLE: if (tgt_q != cur) state_n = RAMP;
        RAMP: if (cur == tgt_q) state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
    settled_n = (state_n == IDLE) && (cur_n == tgt_n);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      fcnt     <= '0;
      tgt_q    <= '0;
      step_q   <= '0;
      cur      <= '0;
      wrt_duty <= 1'b0;
      settled  <= 1'b1;
    end else begin
      state    <= state_n;
      fcnt     <= fcnt_n;
      tgt_q    <= tgt_n;
      step_q   <= step_n;
      cur      <= cur_n;
      wrt_duty <= wrt_n;
      settled  <= settled_n;
    end
  end

  assign duty = cur;

endmodule

// File: tb/tb_duty_slew.sv
// Directed bench for duty_slew with PERIOD=16.
// Expected duty values are hand-computed per transaction.
module tb_duty_slew;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tgt_wrt = 1'b0;
  logic [13:0] tgt = '0;
  logic [7:0]  step = '0;
  logic        estop = 1'b0;
  logic [13:0] duty;
  logic        wrt_duty;
  logic        settled;

  int pass_cnt = 0;
  int tot_cnt = 0;
  int n;

  duty_slew #(.PERIOD(16)) dut (
    .clk(clk), .rst_n(rst_n), .tgt_wrt(tgt_wrt), .tgt(tgt),
    .step(step), .estop(estop), .duty(duty),
    .wrt_duty(wrt_duty), .settled(settled)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    tot_cnt++;
    if (got == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic int sd();
    return int'($signed(duty));
  endfunction

  task automatic wr(input logic [13:0] t, input logic [7:0] s);
    @(negedge clk);
    tgt = t; step = s; tgt_wrt = 1'b1;
    @(negedge clk);
    tgt_wrt = 1'b0;
  endtask

  // cycles until the next wrt_duty, sampled on falling edges
  task automatic wait_wrt(input string tag, output int c);
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!wrt_duty && c < 200);
    if (!wrt_duty) chk({tag, "_timeout"}, 0, 1);
  endtask

  task automatic count_wrt(input int cyc, output int c);
    c = 0;
    repeat (cyc) begin
      @(negedge clk);
      if (wrt_duty) c++;
    end
  endtask

  initial begin
    int d0;
    #12;
    chk("rst_duty", sd(), 0);
    chk("rst_wrt", int'(wrt_duty), 0);
    chk("rst_settled", int'(settled), 1);
    @(negedge clk);
    rst_n = 1'b1;

    // ramp 0 -> 100 step 40
    wr(14'd100, 8'd40);
    wait_wrt("r1a", n);
    chk("r1_d40", sd(), 40);
    wait_wrt("r1b", n);
    chk("r1_gap1", n, 16);
    chk("r1_d80", sd(), 80);
    wait_wrt("r1c", n);
    chk("r1_gap2", n, 16);
    chk("r1_d100", sd(), 100);
    chk("r1_notsettled", int'(settled), 0);
    @(negedge clk);
    chk("r1_settled", int'(settled), 1);
    chk("r1_wrt_low", int'(wrt_duty), 0);

    // 100 -> -30 step 50
    wr(14'h3FE2, 8'd50);
    wait_wrt("r2a", n);
    chk("r2_d50", sd(), 50);
    wait_wrt("r2b", n);
    chk("r2_d0", sd(), 0);
    wait_wrt("r2c", n);
    chk("r2_dm30", sd(), -30);

    // clamp -8192 to -8191, unlimited step
    wr(14'h2000, 8'd0);
    wait_wrt("r3", n);
    chk("r3_clamp", int'(duty), 14'h2001);
    count_wrt(40, n);
    chk("r3_single", n, 0);

    // estop mid-ramp at duty 40
    wr(14'd0, 8'd0);
    wait_wrt("r4a", n);
    chk("r4_d0", sd(), 0);
    wr(14'd100, 8'd40);
    wait_wrt("r4b", n);
    chk("r4_d40", sd(), 40);
    @(negedge clk);
    estop = 1'b1;
    @(negedge clk);
    n = int'(wrt_duty);
    chk("r4_estop_d0", sd(), 0);
    tgt = 14'd500; step = 8'd0; tgt_wrt = 1'b1;
    @(negedge clk);
    if (wrt_duty) n++;
    tgt_wrt = 1'b0;
    @(negedge clk);
    if (wrt_duty) n++;
    estop = 1'b0;
    count_wrt(40, d0);
    chk("r4_one_pulse", n + d0, 1);
    chk("r4_duty", sd(), 0);
    chk("r4_settled", int'(settled), 1);

    // retarget coincident with tick
    wr(14'd200, 8'd50);
    wait_wrt("r5a", n);
    chk("r5_d50", sd(), 50);
    repeat (15) @(negedge clk);
    tgt = 14'd20; step = 8'd5; tgt_wrt = 1'b1;
    @(negedge clk);
    tgt_wrt = 1'b0;
    chk("r5_old_wrt", int'(wrt_duty), 1);
    chk("r5_old_d100", sd(), 100);
    wait_wrt("r5b", n);
    chk("r5_gap", n, 16);
    chk("r5_new_d95", sd(), 95);

    // park at 95, then idle quietly
    wr(14'd95, 8'd0);
    repeat (3) @(negedge clk);
    chk("r6_settled", int'(settled), 1);
    d0 = sd();
    count_wrt(64, n);
    chk("r6_no_wrt", n, 0);
    chk("r6_stable", sd(), d0);

    // zero crossing -5 + 16 = 11
    wr(14'h3FFB, 8'd0);
    wait_wrt("r7a", n);
    chk("r7_dm5", sd(), -5);
    wr(14'd100, 8'd16);
    wait_wrt("r7b", n);
    chk("r7_d11", sd(), 11);

    // reset mid-ramp abandons the ramp
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("r8_rst_d0", sd(), 0);
    @(negedge clk);
    rst_n = 1'b1;
    count_wrt(48, n);
    chk("r8_no_wrt", n, 0);
    chk("r8_idle_d0", sd(), 0);
    chk("r8_settled", int'(settled), 1);

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule

// File: doc/duty_slew.md
DUTY_SLEW -- requirements
Module: duty_slew

Interface
REQ-001 Parameter PERIOD, default 8192, means clock cycles between duty updates and matches the downstream PWM frame length; legal range 2..8192.
REQ-002 Port clk  input  1  means the single clock; all state changes on its rising edge.
REQ-003 Port rst_n  input  1  means the reset, which is asynchronous and active-low.
REQ-004 Port tgt_wrt  input  1  means a one-cycle pulse that latches tgt and step.
REQ-005 Port tgt  input  14  means the target duty in 14-bit two's complement; bit 13 is direction.
REQ-006 Port step  input  8  means the maximum magnitude change per update; 0 means no slew limit.
REQ-007 Port estop  input  1  means a level-sensitive emergency stop that forces duty to 0.
REQ-008 Port duty  output  14  means the registered current duty command in two's complement, feeding the PWM duty input.
REQ-009 Port wrt_duty  output  1  means a registered one-cycle strobe, asserted in the same cycle duty takes its new value.
REQ-010 Port settled  output  1  means high when the current duty equals the latched target and the block is in IDLE.

Function
REQ-011 The block SHALL hold tgt_q[13:0], step_q[7:0], cur[13:0] (driving duty), a frame counter fcnt of ceil(log2(PERIOD)) bits, and a two-state FSM {IDLE, RAMP}.
REQ-012 fcnt SHALL count 0..PERIOD-1 and wrap; tick SHALL be asserted when fcnt == PERIOD-1.
REQ-013 On tgt_wrt with estop low, the block SHALL latch tgt_q <= tgt and step_q <= step; tgt = 14'h2000 (-8192) SHALL be clamped to 14'h2001 (-8191).
REQ-014 The FSM SHALL go IDLE->RAMP when tgt_q != cur, and RAMP->IDLE on the cycle after cur reaches tgt_q.
REQ-015 In RAMP on tick, the block SHALL compute diff = tgt_q - cur sign-extended to 15 bits, with no overflow possible.
REQ-016 If step_q == 0 or |diff| <= step_q, cur SHALL become tgt_q; otherwise cur SHALL become cur + step_q if diff > 0, else cur - step_q.
REQ-017 Each cur update SHALL pulse wrt_duty high for exactly one cycle, coincident with the new duty value; no other cycle SHALL assert wrt_duty.
REQ-018 Zero crossing SHALL be a plain signed add with no special case; -5 with step 16 toward +100 SHALL give 11.
REQ-019 In IDLE, tick SHALL produce no wrt_duty, so the downstream PWM frame is not restarted.
REQ-020 When tgt_wrt and tick coincide, the tick SHALL use the previously latched tgt_q/step_q, and the new values take effect at the next tick.
REQ-021 A tgt_wrt during RAMP SHALL retarget without resetting fcnt.
REQ-022 On estop rising and while estop is high, the block SHALL force cur <= 0, tgt_q <= 0 and fcnt <= 0, hold FSM in IDLE, and ignore tgt_wrt.
REQ-023 If cur was nonzero when estop rose, the block SHALL pulse wrt_duty exactly once, in the cycle cur becomes 0.
REQ-024 settled SHALL equal (state == IDLE) && (cur == tgt_q), registered.

Reset
REQ-025 On rst_n low, the block SHALL asynchronously clear duty=0, wrt_duty=0, settled=1, tgt_q=0, step_q=0, fcnt=0 and state=IDLE.
REQ-026 Reset asserted mid-ramp SHALL abandon the ramp with no further wrt_duty; after rst_n deasserts, the block SHALL stay idle until a new tgt_wrt.

Verification (bench uses PERIOD=16)
REQ-027 Reset, then tgt_wrt tgt=100 step=40 -> wrt_duty at three successive ticks (16 cycles apart), duty 40, 80, 100; settled rises the cycle after duty=100.
REQ-028 From duty=100, tgt_wrt tgt=-30 (14'h3FE2) step=50 -> duty 50, 0, -30, each with one wrt_duty pulse.
REQ-029 tgt_wrt tgt=14'h2000 step=0 -> duty jumps to 14'h2001 at the next tick with a single wrt_duty.
REQ-030 Mid-ramp at duty=40, assert estop for 3 cycles -> duty=0 with one wrt_duty, settled=1, and a tgt_wrt issued during estop is ignored.
REQ-031 tgt_wrt coincident with tick while ramping 0->200 step 50 -> that tick steps toward the old target, and the next tick steps toward the new target.
REQ-032 In IDLE for 64 cycles -> wrt_duty never asserts and duty is stable.
